// File: rtl/load_store_unit.sv
// RV32I data-memory stage: one request/ready transaction per load/store, byte-lane steering and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned h/hu/w accesses complete with ls_err and no memory request.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_valid,
  input  logic            ls_we,
  input  logic [2:0]      ls_funct3,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_busy,
  output logic            ls_done,
  output logic            ls_err,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t st, nxt;

  logic          illegal, misal, tmo;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt, cnt_inc;
  logic [XLEN-1:0] st_data, ld_data;
  logic [3:0]      st_strb;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    illegal = 1'b1;
    case (ls_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = ls_we;
      default:                illegal = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
                 ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign cnt_inc = cnt + 1'b1;
  // TIMEOUT=0 disables the abort; ready in the same cycle still wins.
  assign tmo = (TIMEOUT != 0) && (cnt_inc == TO_V);

  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    st_data = ls_wdata;
    st_strb = 4'b1111;
    case (ls_funct3[1:0])
      2'b00: begin
        st_data = {(XLEN/8){ls_wdata[7:0]}};
        st_strb = 4'b0001 << ls_addr[1:0];
      end
      2'b01: begin
        st_data = {(XLEN/16){ls_wdata[15:0]}};
        st_strb = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (ls_valid) nxt = (illegal || misal) ? DONE : REQ;
      REQ:     if (mem_ready || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ls_busy = ((st == IDLE) && ls_valid) || (st == REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      ls_done   <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
    end else begin
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      case (st)
        IDLE: if (ls_valid) begin
          we_q  <= ls_we;
          f3_q  <= ls_funct3;
          off_q <= ls_addr[1:0];
          cnt   <= '0;
          if (illegal || misal) begin
            ls_done  <= 1'b1;
            ls_err   <= 1'b1;
            ls_rdata <= '0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= {ls_addr[XLEN-1:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= ls_we ? st_strb : 4'b0000;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            ls_done   <= 1'b1;
            ls_rdata  <= we_q ? '0 : ld_data;
          end else if (tmo) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            ls_done   <= 1'b1;
            ls_err    <= 1'b1;
            ls_rdata  <= '0;
            cnt       <= cnt_inc;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes model expectations, monitor and memory responder check them.
module tb_load_store_unit;
  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ls_valid = 1'b0, ls_we = 1'b0;
  logic [2:0]  ls_funct3 = 3'b000;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_busy, ls_done, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .ls_we(ls_we), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_busy(ls_busy), .ls_done(ls_done),
    .ls_err(ls_err), .ls_rdata(ls_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic we; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  typedef struct {logic err; logic [31:0] rdata;} rsp_t;
  typedef struct {int delay; logic [31:0] word;} mem_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  mem_t mem_q[$];
  int total = 0, passed = 0;
  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference: access size in bytes, lane offset and two's-complement arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word, input int delay,
                                output bit has_req, output req_t rq, output rsp_t rs, output int lat);
    int size, lane;
    bit legal, trap;
    logic [31:0] v;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    size  = 1 << f3[1:0];
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && ((addr % size) != 0);
`endif
    lane    = ((addr % 4) / size) * size;
    has_req = legal && !trap;
    rq.addr  = addr & ~32'h3;
    rq.we    = we;
    rq.wstrb = we ? 4'(((1 << size) - 1) << lane) : 4'h0;
    for (int i = 0; i < 4; i++) rq.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    v = word >> (8 * lane);
    if (size < 4) begin
      v = v & ((32'd1 << (8 * size)) - 32'd1);
      if (!f3[2] && v[8*size-1]) v = v - (32'd1 << (8 * size));
    end
    rs.err   = !has_req || (delay >= TO);
    rs.rdata = (rs.err || we) ? 32'h0 : v;
    lat = !has_req ? 1 : ((delay >= TO) ? TO + 1 : delay + 2);
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int delay);
    bit hr;
    req_t rq;
    rsp_t rs;
    int lat, n;
    model(we, f3, addr, wdata, word, delay, hr, rq, rs, lat);
    if (hr) begin
      req_q.push_back(rq);
      mem_q.push_back('{delay, word});
    end
    rsp_q.push_back(rs);
    ls_valid = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
    #1 chk("busy_issue", ls_busy, 1);
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (ls_done) break;
      chk("busy_wait", ls_busy, 1);
      if (n > 40) begin chk("done_timeout", 0, 1); break; end
    end
    chk("latency", n, lat);
    chk("busy_done", ls_busy, 0);
    // valid stays high across the DONE edge; it must not start a second access
    @(negedge clk);
    ls_valid = 1'b0; ls_we = 1'($urandom); ls_funct3 = 3'($urandom);
    ls_addr = $urandom; ls_wdata = $urandom;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Memory responder: ready after the scheduled number of wait cycles, noise outside requests.
  mem_t cur;
  bit   in_req = 1'b0;
  int   wc = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (mem_req && rst) begin
      if (!in_req) begin
        in_req = 1'b1; wc = 0;
        if (mem_q.size() > 0) cur = mem_q.pop_front();
        else cur = '{1000, 32'h0};
      end else wc++;
      if (wc == cur.delay) begin mem_ready = 1'b1; mem_rdata = cur.word; end
    end else begin
      in_req = 1'b0;
      mem_ready = 1'($urandom);
    end
  end

  // Monitor: request contents, request stability, completion responses.
  logic        prev_req = 1'b0, prev_done = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  logic [3:0]  s_strb;
  req_t        mrq;
  rsp_t        mrs;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) chk("unexpected_req", 1, 0);
          else begin
            mrq = req_q.pop_front();
            chk("mem_addr", mem_addr, mrq.addr);
            chk("mem_we", mem_we, mrq.we);
            chk("mem_wstrb", mem_wstrb, mrq.wstrb);
            if (mrq.we) chk("mem_wdata", mem_wdata, mrq.wdata);
          end
          s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we; s_strb = mem_wstrb;
        end else begin
          chk("req_stable", (mem_addr == s_addr) && (mem_wdata == s_wdata) &&
                            (mem_we == s_we) && (mem_wstrb == s_strb), 1);
        end
      end
      if (ls_done) begin
        chk("done_single_pulse", prev_done, 0);
        if (rsp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mrs = rsp_q.pop_front();
          chk("ls_err", ls_err, mrs.err);
          chk("ls_rdata", ls_rdata, mrs.rdata);
        end
      end
      chk("err_only_with_done", !ls_err || ls_done, 1);
      prev_req  = mem_req;
      prev_done = ls_done;
    end else begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_ls_err", ls_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_ls_busy", ls_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h100, 32'h12345678, $urandom, 0);   // sw
    issue(1'b1, 3'b000, 32'h103, 32'h000000AB, $urandom, 0);   // sb
    issue(1'b1, 3'b001, 32'h102, 32'h0000BEEF, $urandom, 1);   // sh
    issue(1'b0, 3'b000, 32'h102, $urandom, 32'h0080FF00, 0);   // lb
    issue(1'b0, 3'b100, 32'h102, $urandom, 32'h0080FF00, 0);   // lbu
    issue(1'b0, 3'b001, 32'h102, $urandom, 32'h0080FF00, 2);   // lh
    issue(1'b0, 3'b000, 32'h101, $urandom, 32'h0080FF00, 0);   // lb
    issue(1'b0, 3'b101, 32'h202, $urandom, 32'h8001_7FFF, 0);  // lhu
    issue(1'b0, 3'b010, 32'h200, $urandom, 32'hCAFEF00D, 3);   // ready on the last allowed cycle
    issue(1'b0, 3'b010, 32'h204, $urandom, 32'h11111111, TO);  // timeout
    issue(1'b1, 3'b010, 32'h208, $urandom, $urandom, 50);      // store timeout
    issue(1'b0, 3'b010, 32'h101, $urandom, 32'hA5A5_5A5A, 0);  // lw misaligned
    issue(1'b0, 3'b001, 32'h103, $urandom, 32'h1234_8765, 0);  // lh misaligned
    issue(1'b1, 3'b100, 32'h300, $urandom, $urandom, 0);       // illegal: store bu
    issue(1'b0, 3'b011, 32'h300, $urandom, $urandom, 0);       // illegal funct3
    issue(1'b0, 3'b110, 32'h300, $urandom, $urandom, 0);

    // Reset while a request is outstanding
    req_q.push_back('{32'h300, 1'b0, 4'h0, 32'h0});
    mem_q.push_back('{1000, 32'h0});
    ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h300;
    repeat (3) @(negedge clk);
    chk("mid_req_high", mem_req, 1);
    rst = 1'b0; ls_valid = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_ls_done", ls_done, 0);
    chk("midrst_ls_busy", ls_busy, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_ls_rdata", ls_rdata, 0);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_idle_no_done", ls_done, 0);
      chk("midrst_idle_no_req", mem_req, 0);
    end

    for (int i = 0; i < 80; i++) begin
      logic [2:0] f3;
      logic       we;
      int         d;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else f3 = legal_f3[$urandom_range(0, 4)];
      we = f3[2] ? ($urandom_range(0, 7) == 0) : 1'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, TO - 1);
      issue(we, f3, $urandom, $urandom, $urandom, d);
    end

    repeat (5) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
